mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs. Takes the M-stage bundle and performs the load/store to data memory over a valid/ready request channel with a separate response channel.
- Handles RV32I byte/half/word alignment and load extension, and stalls upstream while an access is outstanding.
- Drives the registered MEM/WB bundle to writeback.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ALUResultM  in  DATA_WIDTH  effective address, or ALU result for non-memory ops
- WriteDataM  in  DATA_WIDTH  store data (rs2)
- RdM  in  5  destination register
- RegWriteM  in  1  register write enable
- PCPlus4M  in  DATA_WIDTH  link value
- MemWriteM  in  1  store
- ResultSrcM  in  2  01 = load; 00 = ALU; 10 = PC+4
- funct3M  in  3  access size/sign
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = store
- mem_addr  out  DATA_WIDTH  word-aligned address {ALUResultM[31:2],2'b00}
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_resp_valid  in  1  load data valid
- mem_rdata  in  DATA_WIDTH  load word
- StallM  out  1  hold IF/ID/EX/M stages
- misalign_o  out  1  sticky misaligned-access flag (feature-dependent)
- ALUResultW  out  DATA_WIDTH  registered
- ReadDataW  out  DATA_WIDTH  registered, extended load data
- RdW  out  5  registered
- RegWriteW  out  1  registered
- PCPlus4W  out  DATA_WIDTH  registered
- ResultSrcW  out  2  registered

Behaviour:
- Reset:
  - All W outputs are 0, state is IDLE, misalign_o is 0.
  - mem_req_valid and StallM are combinationally 0 while rst_n is low.
- Access classification: access = MemWriteM | (ResultSrcM==2'b01). Non-access ops pass through to W in 1 cycle with StallM=0.
- FSM states are IDLE and WAIT.
  - IDLE:
    - mem_req_valid = access; mem_req_we = MemWriteM.
    - Store with mem_req_ready=1 completes this cycle.
    - Load with mem_req_ready=1 moves to WAIT.
    - Without ready, stay in IDLE and keep the request stable.
  - WAIT:
    - mem_req_valid = 0.
    - On mem_resp_valid, the load completes and the FSM returns to IDLE.
    - mem_resp_valid in IDLE is ignored. A response never arrives in the same cycle as its request handshake.
- Stalling:
  - StallM = access & ~completion (combinational). Upstream holds all M inputs stable while StallM=1.
  - While StallM=1, the W registers capture a bubble: RegWriteW=0, ResultSrcW=00, other W fields are don't-care.
- Completion cycle: W captures ALUResultM, RdM, RegWriteM, PCPlus4M and ResultSrcM. ReadDataW captures the extended load, or 0 for stores.
- Latency:
  - Non-access and store-with-ready: 1 cycle.
  - Load: 2 cycles minimum, plus ready wait, plus response wait.
- Store lanes (by funct3[1:0], a = ALUResultM[1:0]):
  - SB: wstrb = 4'b0001<<a; wdata = byte replicated x4.
  - SH: wstrb = a[1] ? 1100 : 0011; wdata = half replicated x2.
  - SW: wstrb = 1111.
  - Reserved encodings are treated as SW.
- Load extract (funct3, with a selecting the lane):
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half (a[1]).
  - 010 LW.
  - 100 LBU and 101 LHU: zero-extend.
  - Others are treated as LW.
- Reset mid-access: the FSM returns to IDLE. A late response after reset release is ignored.

Optional Feature:
- Macro: MEMSTAGE_MISALIGN_EN.
- Defined:
  - Halfword with a[0]=1, or word with a!=0, issues no memory request and completes in 1 cycle.
  - W captures with RegWriteW forced to 0.
  - misalign_o is set and stays set until reset.
- Undefined: misalign_o is tied 0. The low address bits are ignored for the word address and are used only for lane selection, as above.

Test Plan:
- ALU op, ALUResultM=0x1234, RdM=5, RegWriteM=1 -> next edge ALUResultW=0x1234, RdW=5, RegWriteW=1, StallM=0 throughout.
- SB with addr 0x1003, data 0xAABBCCDD, ready=1 -> same cycle wstrb=1000, wdata=0xDDDDDDDD, mem_addr=0x1000, StallM=0.
- LB at 0x2001, ready held low 2 cycles, response 1 cycle later with rdata=0x0000_80FF:
  - StallM stays high for 3 cycles.
  - W bubbles have RegWriteW=0.
  - Final ReadDataW=0xFFFFFF80 (byte 0x80 sign-extended).
- LHU at 0x2002 with rdata=0x8001_0000 -> ReadDataW=0x00008001. LH at the same address -> 0xFFFF8001.
- rst_n asserted while in WAIT, then released with mem_resp_valid=1 -> response ignored, all W outputs 0, FSM in IDLE.
- With MEMSTAGE_MISALIGN_EN: LW at 0x3002 -> mem_req_valid never asserts, RegWriteW=0 next edge, misalign_o=1 until reset.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage : RV32I memory stage, valid/ready load/store master and MEM/WB reg.
//             MEMSTAGE_MISALIGN_EN enables misaligned-access suppression/flag.
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic                  RegWriteM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            funct3M,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  StallM,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic [1:0]            ResultSrcW
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;
  state_t state_q, state_d;

  logic                  w_access, w_misalign, w_complete, w_req;
  logic [1:0]            w_a, w_size;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_ext;

  logic [DATA_WIDTH-1:0] alu_w_q, rdata_w_q, pc4_w_q, rdata_w_d;
  logic [4:0]            rd_w_q;
  logic                  regwrite_w_q, regwrite_w_d;
  logic [1:0]            rsrc_w_q, rsrc_w_d;

  assign w_access = MemWriteM | (ResultSrcM == 2'b01);
  assign w_a      = ALUResultM[1:0];
  assign w_size   = funct3M[1:0];

`ifdef MEMSTAGE_MISALIGN_EN
  logic misalign_q, misalign_d;
  assign w_misalign = w_access & (((w_size == 2'b01) & w_a[0]) | (w_size[1] & (w_a != 2'b00)));
  assign misalign_d = misalign_q | (w_misalign & (state_q == IDLE));
  assign misalign_o = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    w_req      = 1'b0;
    w_complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_access || w_misalign) begin
          w_complete = 1'b1;
        end else begin
          w_req = 1'b1;
          if (mem_req_ready) begin
            if (MemWriteM) w_complete = 1'b1;
            else           state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          w_complete = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst_n so upstream sees no stall/request while reset is asserted.
  assign mem_req_valid = rst_n & w_req;
  assign StallM        = rst_n & w_access & ~w_complete;
  assign mem_req_we    = MemWriteM;
  assign mem_addr      = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

  always_comb begin
    mem_wdata = WriteDataM;
    mem_wstrb = 4'b1111;
    case (w_size)
      2'b00: begin
        mem_wdata = {4{WriteDataM[7:0]}};
        mem_wstrb = 4'b0001 << w_a;
      end
      2'b01: begin
        mem_wdata = {2{WriteDataM[15:0]}};
        mem_wstrb = w_a[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (w_a)
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      2'b11:   w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = w_a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3M)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // Loads only ever complete from WAIT, so that state qualifies the read data.
  assign regwrite_w_d = w_complete & RegWriteM & ~w_misalign;
  assign rsrc_w_d     = w_complete ? ResultSrcM : 2'b00;
  assign rdata_w_d    = (w_complete && (state_q == WAIT)) ? w_load_ext : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_w_q      <= '0;
      rdata_w_q    <= '0;
      pc4_w_q      <= '0;
      rd_w_q       <= '0;
      regwrite_w_q <= 1'b0;
      rsrc_w_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      alu_w_q      <= ALUResultM;
      rdata_w_q    <= rdata_w_d;
      pc4_w_q      <= PCPlus4M;
      rd_w_q       <= RdM;
      regwrite_w_q <= regwrite_w_d;
      rsrc_w_q     <= rsrc_w_d;
    end
  end

  assign ALUResultW = alu_w_q;
  assign ReadDataW  = rdata_w_q;
  assign PCPlus4W   = pc4_w_q;
  assign RdW        = rd_w_q;
  assign RegWriteW  = regwrite_w_q;
  assign ResultSrcW = rsrc_w_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_stage : randomized scoreboard bench for mem_stage.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        StallM, misalign_o;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;

  mem_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .RegWriteM(RegWriteM),
    .PCPlus4M(PCPlus4M), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .StallM(StallM), .misalign_o(misalign_o),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .RegWriteW(RegWriteW),
    .PCPlus4W(PCPlus4W), .ResultSrcW(ResultSrcW)
  );

  typedef struct {
    logic [31:0] alu, rdat, pc4;
    logic [4:0]  rd;
    logic        rw, mis;
    logic [1:0]  rs;
    int          minst, maxst;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;

  // Stimulus-side state shared with the monitor/responder (written only by the driver).
  logic        drv_active = 1'b0, cur_req = 1'b0, cur_we = 1'b0, mis_exp = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, cur_rdata = '0;
  logic [3:0]  cur_wstrb = '0;
  logic        rdy_rand = 1'b0, no_resp = 1'b0, force_resp = 1'b0;
  int          resp_dly = 0;
  longint      rdy_lo_until = 0;
  longint      cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: v = (w >> (8 * a)) & 32'hFF;
      3'b001, 3'b101: v = (w >> (16 * a[1])) & 32'hFFFF;
      default:        v = w;
    endcase
    if (f3 == 3'b000 && v >= 32'd128)   v = v - 32'd256;
    if (f3 == 3'b001 && v >= 32'h8000)  v = v - 32'h10000;
    return v;
  endfunction

  task automatic drive_nop();
    ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; funct3M = 3'b000;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic [31:0] rdata, input logic [4:0] rd, input logic rw, input logic mw,
                       input logic [1:0] rs, input logic [2:0] f3, input int ov_min, input int ov_max);
    exp_t e;
    logic acc, ld, mis;
    int   n, lane, s, waited;
    acc = mw || (rs == 2'b01);
    ld  = !mw && (rs == 2'b01);
    n   = nbytes(f3[1:0]);
`ifdef MEMSTAGE_MISALIGN_EN
    mis = acc && ((int'(alu[1:0]) % n) != 0);
`else
    mis = 1'b0;
`endif
    lane = (n == 4) ? 0 : (int'(alu[1:0]) / n) * n;
    s = ((1 << n) - 1) << lane;
    cur_wstrb = s[3:0];
    for (int i = 0; i < 4; i++) cur_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    cur_addr  = {alu[31:2], 2'b00};
    cur_we    = mw;
    cur_req   = acc && !mis;
    cur_rdata = rdata;
    if (mis) mis_exp = 1'b1;
    e.alu = alu; e.pc4 = pc4; e.rd = rd; e.rs = rs; e.mis = mis_exp;
    e.rw   = rw && !mis;
    e.rdat = (ld && !mis) ? load_ref(f3, alu[1:0], rdata) : 32'd0;
    if (!acc || mis) begin e.minst = 0; e.maxst = 0; end
    else if (mw)     begin e.minst = 0; e.maxst = 1000; end
    else             begin e.minst = 1; e.maxst = 1000; end
    if (ov_min >= 0) e.minst = ov_min;
    if (ov_max >= 0) e.maxst = ov_max;
    exp_q.push_back(e);
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
    drv_active = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!StallM) break;
      waited++;
      if (waited > 200) begin
        $display("FAIL stall_timeout: StallM still 1 after %0d cycles, required completion", waited);
        $fatal(1, "timeout");
      end
    end
    @(posedge clk); #1;
    drive_nop();
    cur_req = 1'b0;
    drv_active = 1'b0;
  endtask

  task automatic rand_txn();
    int kind;
    kind = $urandom_range(0, 3);
    case (kind)
      0: issue($urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 2'b00, 3'($urandom), -1, -1);
      1: issue($urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 2'b10, 3'($urandom), -1, -1);
      2: issue($urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 2'b01, 3'($urandom), -1, -1);
      default: issue($urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b1, 2'b00, 3'($urandom), -1, -1);
    endcase
  endtask

  // Monitor + memory responder: the only process that steps the counters.
  initial begin
    exp_t e;
    logic pend, bub;
    int   stall_cnt, wait_cnt;
    pend = 1'b0; bub = 1'b0; stall_cnt = 0; wait_cnt = 0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checks++;
        if ({ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, mem_req_valid, StallM, misalign_o} !== '0) begin
          failures++;
          $display("FAIL reset_state: alu=%h rdat=%h pc4=%h rd=%0d rw=%b rs=%b req=%b stall=%b mis=%b, required all 0",
                   ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, mem_req_valid, StallM, misalign_o);
        end
        pend = 1'b0; bub = 1'b0; stall_cnt = 0;
      end else begin
        if (pend) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: completion with empty scoreboard, alu=%h", ALUResultW);
          end else begin
            e = exp_q.pop_front();
            if ({ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, misalign_o} !==
                {e.alu, e.rdat, e.pc4, e.rd, e.rw, e.rs, e.mis}) begin
              failures++;
              $display("FAIL wb_bundle: got alu=%h rdat=%h pc4=%h rd=%0d rw=%b rs=%b mis=%b, required alu=%h rdat=%h pc4=%h rd=%0d rw=%b rs=%b mis=%b",
                       ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, misalign_o,
                       e.alu, e.rdat, e.pc4, e.rd, e.rw, e.rs, e.mis);
            end
            checks++;
            if (stall_cnt < e.minst || stall_cnt > e.maxst) begin
              failures++;
              $display("FAIL stall_cycles: got %0d, required %0d..%0d (alu=%h)", stall_cnt, e.minst, e.maxst, e.alu);
            end
          end
          stall_cnt = 0;
        end else if (bub) begin
          checks++;
          stall_cnt++;
          if (RegWriteW !== 1'b0 || ResultSrcW !== 2'b00) begin
            failures++;
            $display("FAIL wb_bubble: got rw=%b rs=%b, required rw=0 rs=00", RegWriteW, ResultSrcW);
          end
        end
        if (mem_req_valid) begin
          checks++;
          if (!cur_req) begin
            failures++;
            $display("FAIL spurious_req: got mem_req_valid=1 addr=%h, required 0", mem_addr);
          end else if (mem_req_ready) begin
            checks++;
            if ({mem_req_we, mem_addr} !== {cur_we, cur_addr} ||
                (cur_we && {mem_wstrb, mem_wdata} !== {cur_wstrb, cur_wdata})) begin
              failures++;
              $display("FAIL mem_request: got we=%b addr=%h wstrb=%b wdata=%h, required we=%b addr=%h wstrb=%b wdata=%h",
                       mem_req_we, mem_addr, mem_wstrb, mem_wdata, cur_we, cur_addr, cur_wstrb, cur_wdata);
            end
            if (!mem_req_we && !no_resp) wait_cnt = (resp_dly > 0) ? resp_dly : $urandom_range(1, 3);
          end
        end
        pend = drv_active && !StallM;
        bub  = drv_active && StallM;
      end
      @(posedge clk); #2;
      mem_resp_valid = 1'b0;
      mem_rdata = $urandom;
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata = cur_rdata;
        end
      end
      if (force_resp) begin
        mem_resp_valid = 1'b1;
        mem_rdata = cur_rdata;
      end
      if (cyc < rdy_lo_until) mem_req_ready = 1'b0;
      else                    mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required termination");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_nop();
    ALUResultM = 32'h40; ResultSrcM = 2'b01; RegWriteM = 1'b1; funct3M = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    drive_nop();
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h1234, 32'h0, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 3'b010, 0, 0);
    issue(32'h1003, 32'hAABBCCDD, 32'h104, 32'h0, 5'd0, 1'b0, 1'b1, 2'b00, 3'b000, 0, 0);
    rdy_lo_until = cyc + 2;
    resp_dly = 1;
    issue(32'h2001, 32'h0, 32'h108, 32'h000080FF, 5'd7, 1'b1, 1'b0, 2'b01, 3'b000, 3, 3);
    issue(32'h2002, 32'h0, 32'h10C, 32'h80010000, 5'd9, 1'b1, 1'b0, 2'b01, 3'b101, 1, 1);
    issue(32'h2002, 32'h0, 32'h110, 32'h80010000, 5'd10, 1'b1, 1'b0, 2'b01, 3'b001, 1, 1);
`ifdef MEMSTAGE_MISALIGN_EN
    issue(32'h3002, 32'h0, 32'h114, 32'h12345678, 5'd11, 1'b1, 1'b0, 2'b01, 3'b010, 0, 0);
    issue(32'h3000, 32'h0, 32'h118, 32'h0, 5'd12, 1'b1, 1'b0, 2'b00, 3'b010, 0, 0);
`endif
    resp_dly = 0;
    rdy_rand = 1'b1;
    for (int k = 0; k < 300; k++) rand_txn();

    // Reset while a load is outstanding, then release with a stray response.
    rdy_rand = 1'b0;
    no_resp  = 1'b1;
    ALUResultM = 32'h5004; ResultSrcM = 2'b01; MemWriteM = 1'b0; funct3M = 3'b010;
    RegWriteM = 1'b1; RdM = 5'd3;
    cur_req = 1'b1; cur_we = 1'b0; cur_addr = 32'h5004;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    mis_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive_nop();
    cur_req = 1'b0;
    force_resp = 1'b1;
    #2;
    rst_n = 1'b1;
    issue(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 0, 0);
    issue(32'h6008, 32'h0, 32'h6, 32'hCAFEF00D, 5'd4, 1'b1, 1'b0, 2'b01, 3'b010, 1, 1);
    force_resp = 1'b0;
    no_resp = 1'b0;
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) rand_txn();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
